rshift_round_sat: RTL and testbench

Pipelined narrowing stage that returns a widened 2·DATA_WIDTH-bit complex value to DATA_WIDTH bits. It applies an arithmetic right shift, round-half-up and signed saturation. It sits after the twiddle multiplier in each butterfly and undoes the left-shift widening that is applied to operands before multiplication. It carries a valid/ready handshake, a sticky overflow flag and a saturating overflow-event counter for scaling diagnostics.

---
 rtl/fft_pkg.sv | 13 +
 rtl/rnd_sat_lane.sv | 34 +++
 rtl/rshift_round_sat.sv | 84 ++++++++
 tb/tb_rshift_round_sat.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, rounding/saturation constants and sample type for the FFT datapath
package fft_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int RSHIFT_AMOUNT = 8;
    localparam logic [2*DATA_WIDTH:0] ROUND_CONST =
        (RSHIFT_AMOUNT > 0) ? (2*DATA_WIDTH+1)'(1) << (RSHIFT_AMOUNT > 0 ? RSHIFT_AMOUNT - 1 : 0) : '0;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;
endpackage

// File: rtl/rnd_sat_lane.sv
// rnd_sat_lane: round-half-up arithmetic right shift of one wide component, and saturation of the registered result
module rnd_sat_lane
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int RSHIFT_AMOUNT = fft_pkg::RSHIFT_AMOUNT
) (
    input  logic signed [2*DATA_WIDTH-1:0] din,
    output logic signed [2*DATA_WIDTH:0]   shifted,
    input  logic signed [2*DATA_WIDTH:0]   held,
    output logic        [DATA_WIDTH-1:0]   dout,
    output logic                           clipped
);
    localparam int WW = 2*DATA_WIDTH + 1;
    localparam logic signed [WW-1:0] RND =
        (RSHIFT_AMOUNT > 0) ? WW'(1) << (RSHIFT_AMOUNT > 0 ? RSHIFT_AMOUNT - 1 : 0) : '0;
    localparam logic signed [WW-1:0] HI = (WW'(1) << (DATA_WIDTH-1)) - WW'(1);
    localparam logic signed [WW-1:0] LO = -(WW'(1) << (DATA_WIDTH-1));
    logic signed [WW-1:0] sum;
    logic clip_hi, clip_lo;
    // One extra bit of headroom keeps the rounding add from wrapping before the shift
    always_comb begin
        sum = WW'(din) + RND;
        shifted = sum >>> RSHIFT_AMOUNT;
    end
    // Clip the stage-1 value into the narrow signed range
    always_comb begin
        clip_hi = held > HI;
        clip_lo = held < LO;
        clipped = clip_hi | clip_lo;
        dout = clip_hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
               clip_lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : held[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/rshift_round_sat.sv
// rshift_round_sat: two-stage narrowing pipeline (round/shift, then saturate) with handshake and overflow diagnostics
module rshift_round_sat
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int RSHIFT_AMOUNT = fft_pkg::RSHIFT_AMOUNT,
    parameter int CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [2*DATA_WIDTH-1:0] in_re,
    input  logic signed [2*DATA_WIDTH-1:0] in_im,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic        [DATA_WIDTH-1:0]  out_re,
    output logic        [DATA_WIDTH-1:0]  out_im,
    output logic                          ovf_sticky,
    output logic        [CNT_WIDTH-1:0]   ovf_count,
    input  logic                          ovf_clr
);
    localparam int WW = 2*DATA_WIDTH + 1;
    logic signed [WW-1:0] re_sh, im_sh, s1_re, s1_im;
    logic [DATA_WIDTH-1:0] re_n, im_n;
    logic s1_valid, s2_sat, re_clip, im_clip, s2_en, s1_en, xfer;

    rnd_sat_lane #(.DATA_WIDTH(DATA_WIDTH), .RSHIFT_AMOUNT(RSHIFT_AMOUNT)) u_re (
        .din(in_re), .shifted(re_sh), .held(s1_re), .dout(re_n), .clipped(re_clip)
    );
    rnd_sat_lane #(.DATA_WIDTH(DATA_WIDTH), .RSHIFT_AMOUNT(RSHIFT_AMOUNT)) u_im (
        .din(in_im), .shifted(im_sh), .held(s1_im), .dout(im_n), .clipped(im_clip)
    );

    // Stage 2 moves only when its word leaves or it is empty; stage 1 may also fill a bubble under a stalled stage 2
    always_comb begin
        s2_en = out_ready | ~out_valid;
        s1_en = s2_en | ~s1_valid;
        in_ready = s1_en;
        xfer = out_valid & out_ready;
    end

    // Stage 1: rounded, shifted wide values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_re <= '0;
            s1_im <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            s1_re <= re_sh;
            s1_im <= im_sh;
        end
    end

    // Stage 2: saturated narrow values and a single per-word clip flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_re <= '0;
            out_im <= '0;
            s2_sat <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            out_re <= re_n;
            out_im <= im_n;
            s2_sat <= s1_valid & (re_clip | im_clip);
        end
    end

    // Overflow diagnostics count delivered saturated words; clear takes priority over a same-cycle count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
            ovf_count <= '0;
        end else if (xfer && s2_sat) begin
            ovf_sticky <= 1'b1;
            ovf_count <= (&ovf_count) ? ovf_count : ovf_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_rshift_round_sat.sv
// tb_rshift_round_sat: scoreboard bench with a high-level arithmetic reference model
module tb_rshift_round_sat;
    localparam int DW = 16;
    localparam int RS = 8;
    localparam int CW = 8;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [2*DW-1:0] in_re = '0;
    logic [2*DW-1:0] in_im = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [DW-1:0] out_re, out_im;
    logic ovf_sticky;
    logic [CW-1:0] ovf_count;
    logic ovf_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    exp_t q[$];
    int inflight = 0;
    int m_cnt = 0;
    logic m_sticky = 1'b0;
    logic stall_prev = 1'b0;
    logic [DW-1:0] p_re, p_im;
    int saw_backpressure = 0;
    logic rand_ready = 1'b0;

    rshift_round_sat #(.DATA_WIDTH(DW), .RSHIFT_AMOUNT(RS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .ovf_sticky(ovf_sticky),
        .ovf_count(ovf_count), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value/2^RS rounded half-up (floor of value+half), then clipped to the signed range
    function automatic logic [DW:0] ref_lane(input logic [2*DW-1:0] x);
        longint v;
        v = longint'($signed(x));
        if (RS > 0) v = v + (longint'(1) << (RS - 1));
        v = v >>> RS;
        if (v > 32767) return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[DW-1:0]};
    endfunction

    function automatic exp_t ref_word(input logic [2*DW-1:0] re, input logic [2*DW-1:0] im);
        exp_t e;
        logic [DW:0] r, i;
        r = ref_lane(re);
        i = ref_lane(im);
        e.re = r[DW-1:0];
        e.im = i[DW-1:0];
        e.sat = r[DW] | i[DW];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; returns just after the accepting edge with in_valid still high
    task automatic send(input logic [2*DW-1:0] re, input logic [2*DW-1:0] im);
        int n;
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(ref_word(re, im));
                step();
                break;
            end
            n++;
            if (n > 50) begin
                chk("send_timeout", 1, 0);
                step();
                break;
            end
            step();
        end
    endtask

    function automatic logic [2*DW-1:0] rand_val();
        int mode;
        int off;
        mode = $urandom_range(0, 3);
        off = $urandom_range(0, 511) - 256;
        case (mode)
            0: return 32'($urandom_range(0, 1 << 23) - (1 << 22));
            1: return 32'($urandom);
            2: return 32'((32767 << RS) + off);
            default: return 32'(-(32768 << RS) + off);
        endcase
    endfunction

    // Monitor: handshake, stall stability, scoreboard pop and overflow model
    always @(negedge clk) begin
        exp_t e;
        logic oxfer;
        if (!rst_n) begin
            inflight = 0;
            m_cnt = 0;
            m_sticky = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("in_ready", in_ready, out_ready || inflight < 2);
            if (!in_ready) saw_backpressure++;
            chk("ovf_count", ovf_count, m_cnt);
            chk("ovf_sticky", ovf_sticky, m_sticky);
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_re", out_re, p_re);
                chk("stall_im", out_im, p_im);
            end
            oxfer = out_valid && out_ready;
            e.sat = 1'b0;
            if (oxfer) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_re", out_re, e.re);
                    chk("out_im", out_im, e.im);
                end
            end
            if (ovf_clr) begin
                m_cnt = 0;
                m_sticky = 1'b0;
            end else if (oxfer && e.sat) begin
                m_sticky = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            p_re = out_re;
            p_im = out_im;
            inflight = inflight + int'(in_valid && in_ready) - int'(oxfer);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_sticky", ovf_sticky, 0);
        chk("rst_count", ovf_count, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        send(32'h0000_1280, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_c1", out_valid, 0);
        @(negedge clk);
        chk("latency_c2", out_valid, 1);
        chk("dir_round_up", out_re, 16'h0013);
        step();
        send(32'h0000_127F, 32'h0);
        send(32'hFFFF_FF80, 32'hFFFF_FE80);
        send(32'h0080_0000, 32'hFF7F_0000);
        in_valid = 1'b0;
        repeat (4) step();
        chk("dir_sticky", ovf_sticky, 1);
        chk("dir_count_once", ovf_count, 1);

        for (int k = 0; k < 10; k++) send(32'(k * 1000 + 77), 32'(-k * 999));
        in_valid = 1'b0;
        saw_backpressure = 0;
        fork
            for (int k = 0; k < 10; k++) send(rand_val(), rand_val());
            begin
                repeat (3) step();
                out_ready = 1'b0;
                repeat (4) step();
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        repeat (5) step();
        chk("stall_backpressure", saw_backpressure > 0, 1);
        chk("stall_drained", q.size(), 0);

        rand_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            send(rand_val(), rand_val());
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
        end
        in_valid = 1'b0;
        rand_ready = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (5) step();
        chk("rand_drained", q.size(), 0);

        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        for (int k = 0; k < 300; k++) send(32'h7000_0000, 32'h0);
        in_valid = 1'b0;
        repeat (4) step();
        chk("count_saturates", ovf_count, 8'hFF);

        send(32'h8000_0000, 32'h0);
        in_valid = 1'b0;
        step();
        chk("clr_pre_valid", out_valid, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_wins_count", ovf_count, 0);
        chk("clr_wins_sticky", ovf_sticky, 0);

        send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        in_valid = 1'b0;
        repeat (4) step();
        chk("pre_rst_count", ovf_count, 1);
        send(32'h0000_0100, 32'h0);
        send(32'h0000_0200, 32'h0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_count", ovf_count, 0);
        chk("async_rst_sticky", ovf_sticky, 0);
        chk("async_rst_re", out_re, 0);
        q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        send(32'h0000_0380, 32'h0000_0080);
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_c1", out_valid, 0);
        @(negedge clk);
        chk("post_rst_c2", out_valid, 1);
        chk("post_rst_re", out_re, 16'h0004);
        repeat (3) step();
        chk("final_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
